// File: rtl/port_queue_scheduler_pkg.sv
// Shared constants and state encoding for the per-port queue scheduler.
package port_queue_scheduler_pkg;
  localparam int QUEUE_NUB    = 8;
  localparam int WIDTH_WIEGHT = 3;
  localparam int WIDTH_LENGTH = 8;
  localparam int WIDTH_QSEL   = $clog2(QUEUE_NUB);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;
endpackage

// File: rtl/port_queue_scheduler_rr_pick.sv
// Circular priority encoder: first set request at or after 'start', wrapping to 0.
module port_queue_scheduler_rr_pick
  import port_queue_scheduler_pkg::*;
#(
  parameter int N      = QUEUE_NUB,
  parameter int QSEL_W = WIDTH_QSEL
) (
  input  logic [N-1:0]      req,
  input  logic [QSEL_W-1:0] start,
  output logic [QSEL_W-1:0] grant,
  output logic              found
);

  logic [QSEL_W-1:0] idx;

  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = QSEL_W'((int'(start) + i) % N);
      if (!found && req[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

endmodule

// File: rtl/port_queue_scheduler.sv
// Output-port scheduler: strict-priority or WRR queue selection, then per-packet
// read-beat sequencing under downstream ready backpressure.
module port_queue_scheduler
  import port_queue_scheduler_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              dispatch_sel,
  input  logic [QUEUE_NUB*WIDTH_WIEGHT-1:0] wrr_wieght_in,
  input  logic [QUEUE_NUB-1:0]              q_nonempty,
  input  logic [QUEUE_NUB*WIDTH_LENGTH-1:0] q_head_length,
  input  logic                              ready,
  output logic                              rd_vld,
  output logic                              rd_sop,
  output logic                              rd_eop,
  output logic [WIDTH_QSEL-1:0]             rd_queue,
  output logic                              busy
);

  state_e                  state, state_nxt;
  logic [WIDTH_LENGTH-1:0] cnt, cnt_nxt;
  logic [WIDTH_LENGTH-1:0] len;
  logic [WIDTH_QSEL-1:0]   ptr, ptr_nxt;
  logic [WIDTH_WIEGHT-1:0] credit, credit_nxt;
  logic [WIDTH_QSEL-1:0]   grant_q;
  logic                    load;

  logic [WIDTH_WIEGHT-1:0] weight_arr [QUEUE_NUB];
  logic [WIDTH_LENGTH-1:0] len_arr    [QUEUE_NUB];

  for (genvar i = 0; i < QUEUE_NUB; i++) begin : g_unpack
    assign weight_arr[i] = wrr_wieght_in[i*WIDTH_WIEGHT +: WIDTH_WIEGHT];
    assign len_arr[i]    = q_head_length[i*WIDTH_LENGTH +: WIDTH_LENGTH];
  end

  logic [WIDTH_QSEL-1:0] strict_grant, wrr_grant, wrr_start;
  logic                  strict_found, wrr_found;

  // WRR search begins one past the current pointer so the pointer queue is visited last.
  assign wrr_start = (ptr == WIDTH_QSEL'(QUEUE_NUB-1)) ? '0 : ptr + 1'b1;

  port_queue_scheduler_rr_pick #(
    .N      (QUEUE_NUB),
    .QSEL_W (WIDTH_QSEL)
  ) u_rr_pick_strict (
    .req   (q_nonempty),
    .start ('0),
    .grant (strict_grant),
    .found (strict_found)
  );

  port_queue_scheduler_rr_pick #(
    .N      (QUEUE_NUB),
    .QSEL_W (WIDTH_QSEL)
  ) u_rr_pick_wrr (
    .req   (q_nonempty),
    .start (wrr_start),
    .grant (wrr_grant),
    .found (wrr_found)
  );

  assign busy   = (state == XFER);
  assign rd_vld = busy && ready;
  assign rd_sop = rd_vld && (cnt == '0);
  assign rd_eop = rd_vld && (cnt == len);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    ptr_nxt    = ptr;
    credit_nxt = credit;
    grant_q    = '0;
    load       = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (strict_found) begin
          load      = 1'b1;
          state_nxt = XFER;
          if (!dispatch_sel) begin
            grant_q = strict_grant;
          end else if (q_nonempty[ptr] && (credit != '0)) begin
            grant_q    = ptr;
            credit_nxt = credit - 1'b1;
          end else if (wrr_found) begin
            // Credit reload is the only point a new weight is picked up.
            grant_q    = wrr_grant;
            ptr_nxt    = wrr_grant;
            credit_nxt = weight_arr[wrr_grant];
          end
        end
      end
      XFER: begin
        if (rd_vld) begin
          if (cnt == len) state_nxt = IDLE;
          else            cnt_nxt   = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      len      <= '0;
      rd_queue <= '0;
      credit   <= '0;
      ptr      <= WIDTH_QSEL'(QUEUE_NUB-1);
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      ptr    <= ptr_nxt;
      credit <= credit_nxt;
      if (load) begin
        rd_queue <= grant_q;
        len      <= len_arr[grant_q];
      end
    end
  end

endmodule

// File: tb/tb_port_queue_scheduler.sv
// Randomized and directed bench for port_queue_scheduler against a packet-level model.
module tb_port_queue_scheduler;
  import port_queue_scheduler_pkg::*;

  localparam int N  = QUEUE_NUB;
  localparam int W  = WIDTH_WIEGHT;
  localparam int L  = WIDTH_LENGTH;
  localparam int QW = WIDTH_QSEL;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic dispatch_sel = 1'b0;
  logic ready = 1'b0;
  logic [N-1:0] nonempty = '0;
  logic [L-1:0] len_a [N];
  logic [W-1:0] wt_a  [N];
  logic [N*L-1:0] lens;
  logic [N*W-1:0] wts;
  logic rd_vld, rd_sop, rd_eop, busy;
  logic [QW-1:0] rd_queue;

  int checks = 0;
  int errors = 0;

  // Packet-level reference: which packet is in flight and how many words remain.
  bit m_busy;
  int m_q, m_words, m_beat, m_ptr, m_credit;
  int sop_log[$];
  int vld_count;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign lens[g*L +: L] = len_a[g];
    assign wts[g*W +: W]  = wt_a[g];
  end

  always #5 clk = ~clk;

  port_queue_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .dispatch_sel  (dispatch_sel),
    .wrr_wieght_in (wts),
    .q_nonempty    (nonempty),
    .q_head_length (lens),
    .ready         (ready),
    .rd_vld        (rd_vld),
    .rd_sop        (rd_sop),
    .rd_eop        (rd_eop),
    .rd_queue      (rd_queue),
    .busy          (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit ne(input int i);
    return ((nonempty >> i) & N'(1)) != '0;
  endfunction

  function automatic void model_reset();
    m_busy = 0; m_q = 0; m_words = 0; m_beat = 0; m_ptr = N-1; m_credit = 0;
  endfunction

  function automatic void model_update();
    int q;
    q = 0;
    if (m_busy) begin
      if (ready) begin
        m_beat++;
        if (m_beat == m_words) m_busy = 0;
      end
    end else if (nonempty != '0) begin
      if (!dispatch_sel) begin
        for (int i = N-1; i >= 0; i--) if (ne(i)) q = i;
      end else if (ne(m_ptr) && m_credit > 0) begin
        q = m_ptr;
        m_credit--;
      end else begin
        for (int k = N; k >= 1; k--) if (ne((m_ptr + k) % N)) q = (m_ptr + k) % N;
        m_ptr = q;
        m_credit = int'(wt_a[q]);
      end
      m_busy = 1; m_q = q; m_words = int'(len_a[q]) + 1; m_beat = 0;
    end
  endfunction

  // Entered at posedge+1 with inputs already applied; leaves at the next posedge+1.
  task automatic step();
    bit ev, es, ee;
    #3;
    ev = m_busy && ready;
    es = ev && (m_beat == 0);
    ee = ev && (m_beat == m_words - 1);
    chk("rd_vld", 32'(rd_vld), 32'(ev));
    chk("rd_sop", 32'(rd_sop), 32'(es));
    chk("rd_eop", 32'(rd_eop), 32'(ee));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("rd_queue", 32'(rd_queue), m_q);
    if (rd_sop === 1'b1) sop_log.push_back(int'(rd_queue));
    if (rd_vld === 1'b1) vld_count++;
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    chk("rst_vld", 32'(rd_vld), 0);
    chk("rst_sop", 32'(rd_sop), 0);
    chk("rst_eop", 32'(rd_eop), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_queue", 32'(rd_queue), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    sop_log.delete();
  endtask

  // Expected grant order packed one nibble per packet, first packet in the low nibble.
  task automatic check_log(input string tag, input logic [31:0] seq, input int n);
    chk({tag, "_count"}, sop_log.size(), n);
    for (int i = 0; i < n; i++)
      if (i < sop_log.size()) chk(tag, sop_log[i], 32'(seq[4*i +: 4]));
    sop_log.delete();
  endtask

  task automatic clear_inputs();
    for (int q = 0; q < N; q++) begin
      len_a[q] = '0;
      wt_a[q]  = '0;
    end
    nonempty = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

  initial begin
    clear_inputs();
    model_reset();
    @(posedge clk);
    #1;
    do_reset();
    ready = 1'b1;

    // Strict priority: queue 2 (4 words) then queue 5 (1 word).
    dispatch_sel = 1'b0;
    len_a[2] = 8'd3;
    len_a[5] = 8'd0;
    nonempty = 8'h24;
    step();
    nonempty = 8'h20;
    repeat (5) step();
    nonempty = 8'h00;
    repeat (2) step();
    check_log("strict_order", 32'h52, 2);

    // WRR with q0 weight 1 and q1 weight 0.
    do_reset();
    clear_inputs();
    dispatch_sel = 1'b1;
    wt_a[0] = 3'd1;
    nonempty = 8'h03;
    repeat (12) step();
    check_log("wrr_order", 32'h0010_0100, 6);
    nonempty = 8'h00;
    step();

    // Ready pattern 1,0,0 repeating over a 5-word packet.
    dispatch_sel = 1'b0;
    len_a[3] = 8'd4;
    nonempty = 8'h08;
    ready = 1'b1;
    step();
    nonempty = 8'h00;
    vld_count = 0;
    for (int i = 0; i < 16; i++) begin
      ready = (i % 3 == 0);
      step();
    end
    chk("stall_beats", vld_count, 5);
    check_log("stall_queue", 32'h3, 1);

    // Inputs changed mid-packet must not disturb the packet in flight.
    ready = 1'b1;
    dispatch_sel = 1'b0;
    len_a[1] = 8'd5;
    nonempty = 8'h02;
    step();
    nonempty = 8'hC0;
    dispatch_sel = 1'b1;
    for (int q = 0; q < N; q++) begin
      len_a[q] = 8'($urandom_range(0, 3));
      wt_a[q]  = 3'($urandom_range(0, 7));
    end
    repeat (6) step();
    step();
    nonempty = 8'h00;
    for (int i = 0; i < 20 && m_busy; i++) step();
    step();
    chk("mid_count", sop_log.size(), 2);
    if (sop_log.size() > 0) chk("mid_first", sop_log[0], 1);
    sop_log.delete();

    // Asynchronous reset on the third beat of an 8-word packet.
    do_reset();
    clear_inputs();
    dispatch_sel = 1'b0;
    len_a[4] = 8'd7;
    nonempty = 8'h10;
    step();
    nonempty = 8'h00;
    repeat (2) step();
    do_reset();
    dispatch_sel = 1'b1;
    for (int q = 0; q < N; q++) wt_a[q] = 3'd2;
    for (int q = 0; q < N; q++) len_a[q] = 8'd0;
    nonempty = 8'hFF;
    repeat (8) step();
    check_log("rst_wrr_restart", 32'h1000, 4);
    nonempty = 8'h00;
    step();

    // WRR wrap between queues 7 and 0 with zero weights.
    do_reset();
    clear_inputs();
    dispatch_sel = 1'b1;
    nonempty = 8'h81;
    repeat (8) step();
    check_log("wrr_wrap", 32'h7070, 4);
    nonempty = 8'h00;
    step();

    // Randomized traffic, including occasional 256-word packets.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      ready = ($urandom_range(0, 3) != 0);
      nonempty = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      dispatch_sel = 1'($urandom_range(0, 1));
      for (int q = 0; q < N; q++) begin
        wt_a[q]  = 3'($urandom_range(0, 7));
        len_a[q] = ($urandom_range(0, 63) == 0) ? 8'd255 : 8'($urandom_range(0, 6));
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
